// File: rtl/shared_resource_arbiter_n_pkg.sv
// Shared types and helpers for the round-robin arbiter in front of the shared pipelined resource.
// Stage entries are sized for the widest supported configuration (16 channels, 64-bit payload).
package sra_pkg;

    localparam int SRA_CNT_W      = 16;
    localparam int SRA_TAG_MAX_W  = 4;
    localparam int SRA_DATA_MAX_W = 64;

    typedef struct packed {
        logic                      valid;
        logic [SRA_TAG_MAX_W-1:0]  tag;
        logic [SRA_DATA_MAX_W-1:0] data;
    } sra_entry_t;

    function automatic int sra_clog2(input int n);
        int w;
        w = 1;
        while ((32'sd1 <<< w) < n) begin
            w = w + 32'sd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/shared_resource_arbiter_n_rr_picker.sv
// Round-robin priority picker: first set request at or above ptr, wrapping to 0.
module rr_picker #(
    parameter int NCH   = 4,
    parameter int PTR_W = 2
) (
    input  logic [NCH-1:0]   req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NCH-1:0]   grant
);

    logic [2*NCH-1:0] req_dbl_s;
    logic [2*NCH-1:0] req_rot_s;
    logic [NCH-1:0]   req_low_s;
    logic [NCH-1:0]   iso_s;
    logic [2*NCH-1:0] iso_dbl_s;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        req_dbl_s = {req, req};
        req_rot_s = req_dbl_s >> ptr;
        req_low_s = req_rot_s[NCH-1:0];
        iso_s     = req_low_s & (~req_low_s + {{(NCH-1){1'b0}}, 1'b1});
        iso_dbl_s = {iso_s, iso_s} << ptr;
        grant     = iso_dbl_s[2*NCH-1:NCH];
    end

endmodule

// File: rtl/shared_resource_arbiter_n.sv
// N-channel round-robin arbiter feeding a LAT-deep "+1" pipeline with per-channel flush.
// Optional SRA_GRANT_STATS_EN adds saturating per-channel acceptance counters (grant_count). W <= 64.
module shared_resource_arbiter_n
    import sra_pkg::*;
#(
    parameter int NCH = 4,
    parameter int W   = 32,
    parameter int LAT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   req,
    input  logic [NCH*W-1:0] req_data,
    input  logic [NCH-1:0]   flush,
    output logic [NCH-1:0]   grant,
    output logic [NCH-1:0]   rsp_valid,
    output logic [W-1:0]     rsp_data,
`ifdef SRA_GRANT_STATS_EN
    output logic [NCH*SRA_CNT_W-1:0] grant_count,
`endif
    output logic             busy
);

    localparam int TAG_W = sra_clog2(NCH);

    logic [TAG_W-1:0] rr_ptr_r;
    sra_entry_t       stage_r [LAT];
    logic [NCH-1:0]   eligible_s;
    logic [NCH-1:0]   pick_s;
    logic [TAG_W-1:0] grant_idx_s;
    logic [TAG_W-1:0] next_ptr_s;
    logic [W-1:0]     sel_data_s;
    logic             accept_s;
    sra_entry_t       last_s;
    logic             out_valid_s;
    logic             unused_data_s;

    function automatic logic tag_flushed(input logic [SRA_TAG_MAX_W-1:0] tag,
                                         input logic [NCH-1:0] f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            hit = hit | (f[i] & (tag == SRA_TAG_MAX_W'(i)));
        end
        return hit;
    endfunction

    assign eligible_s = req & ~flush;

    rr_picker #(.NCH(NCH), .PTR_W(TAG_W)) u_picker (
        .req   (eligible_s),
        .ptr   (rr_ptr_r),
        .grant (pick_s)
    );

    // Grant is forced low while reset is held; winner index and payload are mux-free OR trees.
    always_comb begin
        grant       = reset ? {NCH{1'b0}} : pick_s;
        sel_data_s  = {W{1'b0}};
        grant_idx_s = {TAG_W{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            sel_data_s  = sel_data_s  | (req_data[i*W +: W] & {W{pick_s[i]}});
            grant_idx_s = grant_idx_s | (TAG_W'(i) & {TAG_W{pick_s[i]}});
        end
        accept_s   = |grant;
        next_ptr_s = (grant_idx_s == TAG_W'(NCH-1)) ? {TAG_W{1'b0}} : grant_idx_s + TAG_W'(1);
    end

    // Pointer and pipeline stages; a flushed tag loses its valid bit as it moves forward.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_r <= {TAG_W{1'b0}};
            for (int k = 0; k < LAT; k++) begin
                stage_r[k] <= '0;
            end
        end else begin
            rr_ptr_r <= accept_s ? next_ptr_s : rr_ptr_r;
            stage_r[0].valid <= accept_s;
            stage_r[0].tag   <= SRA_TAG_MAX_W'(grant_idx_s);
            stage_r[0].data  <= SRA_DATA_MAX_W'(sel_data_s);
            for (int k = 1; k < LAT; k++) begin
                stage_r[k].valid <= stage_r[k-1].valid & ~tag_flushed(stage_r[k-1].tag, flush);
                stage_r[k].tag   <= stage_r[k-1].tag;
                stage_r[k].data  <= stage_r[k-1].data;
            end
        end
    end

    // Output stage: a flush on the owning channel kills the response in the same cycle.
    always_comb begin
        last_s      = stage_r[LAT-1];
        out_valid_s = last_s.valid & ~tag_flushed(last_s.tag, flush);
        rsp_valid   = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            rsp_valid[i] = out_valid_s & (last_s.tag == SRA_TAG_MAX_W'(i));
        end
        rsp_data = out_valid_s ? (last_s.data[W-1:0] + W'(1)) : {W{1'b0}};
        busy     = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            busy = busy | stage_r[k].valid;
        end
    end

    assign unused_data_s = ^last_s.data;

`ifdef SRA_GRANT_STATS_EN
    logic [SRA_CNT_W-1:0] cnt_r [NCH];

    // Saturating per-channel acceptance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i] <= {SRA_CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (grant[i] && (cnt_r[i] != {SRA_CNT_W{1'b1}})) begin
                    cnt_r[i] <= cnt_r[i] + SRA_CNT_W'(1);
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        grant_count = {(NCH*SRA_CNT_W){1'b0}};
        for (int i = 0; i < NCH; i++) begin
            grant_count[i*SRA_CNT_W +: SRA_CNT_W] = cnt_r[i];
        end
    end
`endif

endmodule

// File: tb/tb_shared_resource_arbiter_n.sv
// Directed self-checking bench for shared_resource_arbiter_n (NCH=4, W=32, LAT=3).
module tb_shared_resource_arbiter_n;

    logic         clk;
    logic         reset;
    logic [3:0]   req;
    logic [127:0] req_data;
    logic [3:0]   flush;
    logic [3:0]   grant;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_data;
    logic         busy;
`ifdef SRA_GRANT_STATS_EN
    logic [63:0]  grant_count;
`endif

    int checks   = 0;
    int failures = 0;

    shared_resource_arbiter_n #(.NCH(4), .W(32), .LAT(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .flush     (flush),
        .grant     (grant),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
`ifdef SRA_GRANT_STATS_EN
        .grant_count (grant_count),
`endif
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [31:0] v);
        req_data[ch*32 +: 32] = v;
    endtask

    initial begin
        reset = 1'b1; req = 4'b1111; req_data = '0; flush = 4'b0000;

        // Reset state: grant suppressed even with all requests high.
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // Single request, channel 0, data 5 -> 6 after three cycles.
        next_cycle(); reset = 1'b0; req = 4'b0001; set_data(0, 32'd5);
        @(negedge clk); chk("t31_grant", 32'(grant), 32'h1);
        next_cycle(); req = 4'b0000;
        @(negedge clk); chk("t31_rv_c1", 32'(rsp_valid), 32'h0); chk("t31_busy", 32'(busy), 32'h1);
        next_cycle();
        @(negedge clk); chk("t31_rv_c2", 32'(rsp_valid), 32'h0);
        next_cycle();
        @(negedge clk); chk("t31_rv", 32'(rsp_valid), 32'h1); chk("t31_data", rsp_data, 32'd6);
        next_cycle();
        @(negedge clk); chk("t31_rv_after", 32'(rsp_valid), 32'h0);
        chk("t31_data_after", rsp_data, 32'h0); chk("t31_busy_after", 32'(busy), 32'h0);

        // Reset pulse, then all four channels: grants and responses in 0..3 order.
        next_cycle(); reset = 1'b1;
        next_cycle(); reset = 1'b0; req_data = '0;
        for (int c = 0; c < 8; c++) begin
            req = (c < 4) ? 4'b1111 : 4'b0000;
            @(negedge clk);
            if (c < 4) chk($sformatf("t32_grant%0d", c), 32'(grant), 32'h1 << c);
            if (c >= 3 && c < 7) begin
                chk($sformatf("t32_rv%0d", c - 3), 32'(rsp_valid), 32'h1 << (c - 3));
                chk($sformatf("t32_data%0d", c - 3), rsp_data, 32'd1);
            end else begin
                chk($sformatf("t32_idle%0d", c), 32'(rsp_valid), 32'h0);
            end
            next_cycle();
        end

        // Wrap: channel 1 with all-ones data -> 0 (pointer is back at 0).
        req = 4'b0010; set_data(1, 32'hFFFF_FFFF);
        @(negedge clk); chk("t33_grant", 32'(grant), 32'h2);
        next_cycle(); req = 4'b0000;
        next_cycle();
        @(negedge clk); chk("t33_rv_pre", 32'(rsp_valid), 32'h0); chk("t33_data_pre", rsp_data, 32'h0);
        next_cycle();
        @(negedge clk); chk("t33_rv", 32'(rsp_valid), 32'h2); chk("t33_data", rsp_data, 32'h0);

        // Pointer now 2: channel 2 then 0 accepted, channel 2 flushed in flight.
        next_cycle(); req = 4'b0101; set_data(0, 32'h10); set_data(2, 32'h20);
        @(negedge clk); chk("t34_grant2", 32'(grant), 32'h4);
        next_cycle(); req = 4'b0001; flush = 4'b0100;
        @(negedge clk); chk("t34_grant0", 32'(grant), 32'h1);
        next_cycle(); req = 4'b0000; flush = 4'b0000;
        @(negedge clk); chk("t34_busy", 32'(busy), 32'h1);
        next_cycle();
        @(negedge clk); chk("t34_no_ch2", 32'(rsp_valid), 32'h0);
        next_cycle();
        @(negedge clk); chk("t34_rv0", 32'(rsp_valid), 32'h1); chk("t34_data0", rsp_data, 32'h11);
        next_cycle();
        @(negedge clk); chk("t34_rv_after", 32'(rsp_valid), 32'h0); chk("t34_idle", 32'(busy), 32'h0);

        // Pointer now 1: combinational kill of the last-stage entry.
        next_cycle(); req = 4'b0010; set_data(1, 32'd7);
        @(negedge clk); chk("kill_grant", 32'(grant), 32'h2);
        next_cycle(); req = 4'b0000;
        next_cycle();
        next_cycle(); flush = 4'b0010;
        @(negedge clk); chk("kill_rv", 32'(rsp_valid), 32'h0); chk("kill_data", rsp_data, 32'h0);
        chk("kill_busy", 32'(busy), 32'h1);
        next_cycle(); flush = 4'b0000;
        @(negedge clk); chk("kill_idle", 32'(busy), 32'h0);

        // Pointer now 2: request and flush together on channel 1 -> no grant, pointer holds.
        next_cycle(); req = 4'b0010; flush = 4'b0010;
        @(negedge clk); chk("t35_grant", 32'(grant), 32'h0);
        next_cycle(); req = 4'b1111; flush = 4'b0000;
        @(negedge clk); chk("t35_ptr_hold", 32'(grant), 32'h4);
        next_cycle();
        @(negedge clk); chk("t36_fill3", 32'(grant), 32'h8);
        next_cycle();
        @(negedge clk); chk("t36_fill0", 32'(grant), 32'h1);

        // Three entries in flight; asynchronous reset discards them at once.
        next_cycle(); reset = 1'b1;
        #1;
        chk("t36_busy", 32'(busy), 32'h0); chk("t36_rv", 32'(rsp_valid), 32'h0);
        chk("t36_data", rsp_data, 32'h0); chk("t36_grant", 32'(grant), 32'h0);
        next_cycle(); reset = 1'b0; req = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("t36_quiet%0d", c), 32'({busy, rsp_valid}), 32'h0);
            next_cycle();
        end
        req = 4'b1000; set_data(3, 32'd9);
        @(negedge clk); chk("t36_grant3", 32'(grant), 32'h8);
        next_cycle(); req = 4'b0000;
        next_cycle();
        next_cycle();
        @(negedge clk); chk("t36_rv3", 32'(rsp_valid), 32'h8); chk("t36_data3", rsp_data, 32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
